// File: rtl/acl_spi_pkg.sv
// Shared constants and encodings for the ADXL362-style SPI responder.
// Command bytes, register addresses, fixed register values and FSM/op encodings.
package acl_spi_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  localparam logic [5:0] ADDR_DEVID_AD  = 6'h00;
  localparam logic [5:0] ADDR_DEVID_MST = 6'h01;
  localparam logic [5:0] ADDR_PARTID    = 6'h02;
  localparam logic [5:0] ADDR_XDATA     = 6'h08;
  localparam logic [5:0] ADDR_YDATA     = 6'h09;
  localparam logic [5:0] ADDR_ZDATA     = 6'h0A;
  localparam logic [5:0] ADDR_STATUS    = 6'h0B;
  localparam logic [5:0] ADDR_POWER_CTL = 6'h2D;

  localparam logic [7:0] DEVID_MST_VAL = 8'h1D;
  // data ready + awake
  localparam logic [7:0] STATUS_VAL    = 8'h41;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_IGNORE
  } state_t;

  typedef enum logic {
    OP_WR,
    OP_RD
  } op_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous SPI pin with registered-edge detect.
// Latency SYNC_STAGES cycles to the pulse; no backpressure (single-cycle rise/fall pulses).
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_din,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_dly  <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
      r_dly  <= w_sync;
    end
  end

  assign o_rise = w_sync & ~r_dly;
  assign o_fall = ~w_sync & r_dly;

endmodule

// File: rtl/acl_spi_responder.sv
// SPI mode-0 responder emulating the ADXL362 register file (0x0A write / 0x0B read, auto-increment).
// Pins are oversampled in the system clock; sclk high/low must each last >= 6 clocks.
module acl_spi_responder
  import acl_spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DEVID_AD    = 8'hAD,
  parameter logic [7:0] PARTID      = 8'hF2
) (
  input  logic       i_clk100mhz,
  input  logic       i_reset,
  input  logic       i_sclk,
  input  logic       i_mosi,
  input  logic       i_cs,
  output logic       o_miso,
  output logic       o_miso_en,
  input  logic [7:0] i_x_data,
  input  logic [7:0] i_y_data,
  input  logic [7:0] i_z_data,
  output logic [7:0] o_power_ctl,
  output logic       o_wr_strobe,
  output logic [5:0] o_wr_addr
);

  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs_rise;
  logic w_cs_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .i_clk   (i_clk100mhz),
    .i_reset (i_reset),
    .i_din   (i_sclk),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  // cs idles high so a reset with cs released does not fake a frame start
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .i_clk   (i_clk100mhz),
    .i_reset (i_reset),
    .i_din   (i_cs),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   w_mosi;

  always_ff @(posedge i_clk100mhz) begin
    if (i_reset) begin
      r_mosi_sync <= '0;
    end else begin
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
    end
  end

  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  state_t     r_state;
  op_t        r_op;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift_in;
  logic [5:0] r_addr;
  logic [7:0] r_x_shadow;
  logic [7:0] r_y_shadow;
  logic [7:0] r_z_shadow;
  logic [7:0] r_power_ctl;
  logic [7:0] r_tx_shift;
  logic       r_miso;
  logic       r_miso_en;
  logic       r_wr_strobe;
  logic [5:0] r_wr_addr;

  logic [7:0] w_byte_in;
  logic [7:0] w_rd_byte;
  logic       w_shift_state;

  assign w_byte_in     = {r_shift_in[6:0], w_mosi};
  assign w_shift_state = (r_state == ST_CMD) || (r_state == ST_ADDR) || (r_state == ST_DATA);

  always_comb begin
    w_rd_byte = 8'h00;
    case (r_addr)
      ADDR_DEVID_AD:  w_rd_byte = DEVID_AD;
      ADDR_DEVID_MST: w_rd_byte = DEVID_MST_VAL;
      ADDR_PARTID:    w_rd_byte = PARTID;
      ADDR_XDATA:     w_rd_byte = r_x_shadow;
      ADDR_YDATA:     w_rd_byte = r_y_shadow;
      ADDR_ZDATA:     w_rd_byte = r_z_shadow;
      ADDR_STATUS:    w_rd_byte = STATUS_VAL;
      ADDR_POWER_CTL: w_rd_byte = r_power_ctl;
      default:        w_rd_byte = 8'h00;
    endcase
  end

  always_ff @(posedge i_clk100mhz) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_WR;
      r_bit_cnt   <= 3'd0;
      r_shift_in  <= 8'h00;
      r_addr      <= 6'd0;
      r_x_shadow  <= 8'h00;
      r_y_shadow  <= 8'h00;
      r_z_shadow  <= 8'h00;
      r_power_ctl <= 8'h00;
      r_tx_shift  <= 8'h00;
      r_miso      <= 1'b0;
      r_miso_en   <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= 6'd0;
    end else begin
      r_wr_strobe <= 1'b0;
      // cs release beats a coincident 8th sclk edge, dropping any partial byte
      if (w_cs_rise) begin
        r_state   <= ST_IDLE;
        r_bit_cnt <= 3'd0;
        r_miso    <= 1'b0;
        r_miso_en <= 1'b0;
      end else if (w_cs_fall) begin
        r_state    <= ST_CMD;
        r_bit_cnt  <= 3'd0;
        r_x_shadow <= i_x_data;
        r_y_shadow <= i_y_data;
        r_z_shadow <= i_z_data;
        r_miso     <= 1'b0;
        r_miso_en  <= 1'b0;
      end else begin
        if (w_sclk_rise && w_shift_state) begin
          r_bit_cnt  <= r_bit_cnt + 3'd1;
          r_shift_in <= w_byte_in;
          if (r_bit_cnt == 3'd7) begin
            case (r_state)
              ST_CMD: begin
                if (w_byte_in == CMD_WRITE) begin
                  r_op    <= OP_WR;
                  r_state <= ST_ADDR;
                end else if (w_byte_in == CMD_READ) begin
                  r_op    <= OP_RD;
                  r_state <= ST_ADDR;
                end else begin
                  r_state <= ST_IGNORE;
                end
              end
              ST_ADDR: begin
                r_addr  <= w_byte_in[5:0];
                r_state <= ST_DATA;
              end
              ST_DATA: begin
                r_addr <= r_addr + 6'd1;
                if (r_op == OP_WR) begin
                  r_wr_strobe <= 1'b1;
                  r_wr_addr   <= r_addr;
                  if (r_addr == ADDR_POWER_CTL) begin
                    r_power_ctl <= w_byte_in;
                  end
                end
              end
              default: ;
            endcase
          end
        end
        // bit counter at 0 on a falling edge marks a byte boundary: load the next register
        if (w_sclk_fall && (r_state == ST_DATA) && (r_op == OP_RD)) begin
          r_miso_en <= 1'b1;
          if (r_bit_cnt == 3'd0) begin
            r_miso     <= w_rd_byte[7];
            r_tx_shift <= {w_rd_byte[6:0], 1'b0};
          end else begin
            r_miso     <= r_tx_shift[7];
            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
          end
        end
        if (r_state == ST_IGNORE) begin
          r_miso_en <= 1'b0;
          r_miso    <= 1'b0;
        end
      end
    end
  end

  assign o_miso      = r_miso;
  assign o_miso_en   = r_miso_en;
  assign o_power_ctl = r_power_ctl;
  assign o_wr_strobe = r_wr_strobe;
  assign o_wr_addr   = r_wr_addr;

endmodule

// File: tb/tb_acl_spi_responder.sv
// Bench for acl_spi_responder: bit-banged SPI mode-0 master with a read-data scoreboard.
module tb_acl_spi_responder;

  localparam int HP = 8;
  localparam int SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       sclk;
  logic       mosi;
  logic       cs;
  logic       miso;
  logic       miso_en;
  logic [7:0] x_data;
  logic [7:0] y_data;
  logic [7:0] z_data;
  logic [7:0] power_ctl;
  logic       wr_strobe;
  logic [5:0] wr_addr;

  always #5 clk = ~clk;

  acl_spi_responder #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEVID_AD    (8'hAD),
    .PARTID      (8'hF2)
  ) dut (
    .i_clk100mhz (clk),
    .i_reset     (reset),
    .i_sclk      (sclk),
    .i_mosi      (mosi),
    .i_cs        (cs),
    .o_miso      (miso),
    .o_miso_en   (miso_en),
    .i_x_data    (x_data),
    .i_y_data    (y_data),
    .i_z_data    (z_data),
    .o_power_ctl (power_ctl),
    .o_wr_strobe (wr_strobe),
    .o_wr_addr   (wr_addr)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];

  int         strobe_cnt = 0;
  logic [5:0] strobe_addr = 6'd0;
  int         en_cnt = 0;

  always @(negedge clk) begin
    if (wr_strobe) begin
      strobe_cnt++;
      strobe_addr = wr_addr;
    end
    if (miso_en) en_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int b = 7; b >= 8 - nbits; b--) begin
      mosi = tx[b];
      cyc(HP);
      sclk = 1'b1;
      rx = {rx[6:0], miso};
      cyc(HP);
      sclk = 1'b0;
    end
  endtask

  // Sends tx_q as one frame; bytes from index 'skip' on are scored against exp_q.
  task automatic run_txn(input int skip, input int chg_after);
    logic [7:0] rx;
    logic [7:0] e;
    int         t;
    cs = 1'b0;
    cyc(HP);
    for (int i = 0; i < tx_q.size(); i++) begin
      spi_bits(tx_q[i], 8, rx);
      if (i == chg_after) x_data = 8'h99;
      if (i >= skip) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("rd_byte%0d", i), {24'd0, rx}, {24'd0, e});
        end
      end
    end
    cyc(HP);
    cs = 1'b1;
    t = 0;
    while (miso_en && t < 20) begin
      cyc(1);
      t++;
    end
    check($sformatf("miso_en_fall_late_%0d", t), {31'd0, t > SYNC_STAGES + 2}, 32'd0);
    tx_q.delete();
    cyc(2 * HP);
  endtask

  initial begin
    logic [7:0] rx;
    int s0;
    int e0;

    reset  = 1'b1;
    sclk   = 1'b0;
    mosi   = 1'b0;
    cs     = 1'b1;
    x_data = 8'h00;
    y_data = 8'h00;
    z_data = 8'h00;
    cyc(4);
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_miso_en", {31'd0, miso_en}, 32'd0);
    check("rst_power_ctl", {24'd0, power_ctl}, 32'h00);
    check("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
    check("rst_wr_addr", {26'd0, wr_addr}, 32'd0);
    reset = 1'b0;
    cyc(4);

    // DEVID read
    tx_q = '{8'h0B, 8'h00, 8'h00};
    exp_q.push_back(8'hAD);
    run_txn(2, -1);

    // axis burst; x changes after the address byte, shadow must hold
    x_data = 8'h12; y_data = 8'h34; z_data = 8'h56;
    tx_q = '{8'h0B, 8'h08, 8'h00, 8'h00, 8'h00};
    exp_q.push_back(8'h12); exp_q.push_back(8'h34); exp_q.push_back(8'h56);
    run_txn(2, 1);

    // POWER_CTL write and readback
    s0 = strobe_cnt;
    tx_q = '{8'h0A, 8'h2D, 8'h02};
    run_txn(3, -1);
    check("wr_power_ctl", {24'd0, power_ctl}, 32'h02);
    check("wr_strobe_count", strobe_cnt - s0, 32'd1);
    check("wr_strobe_addr", {26'd0, strobe_addr}, 32'h2D);
    tx_q = '{8'h0B, 8'h2D, 8'h00};
    exp_q.push_back(8'h02);
    run_txn(2, -1);

    // address wrap 0x3F -> 0x00
    tx_q = '{8'h0B, 8'h3F, 8'h00, 8'h00};
    exp_q.push_back(8'h00); exp_q.push_back(8'hAD);
    run_txn(2, -1);

    // partial data byte discarded
    s0 = strobe_cnt;
    cs = 1'b0;
    cyc(HP);
    spi_bits(8'h0A, 8, rx);
    spi_bits(8'h2D, 8, rx);
    spi_bits(8'h00, 4, rx);
    cyc(HP);
    cs = 1'b1;
    cyc(2 * HP);
    check("partial_power_ctl", {24'd0, power_ctl}, 32'h02);
    check("partial_no_strobe", strobe_cnt - s0, 32'd0);

    // unknown command is ignored
    s0 = strobe_cnt;
    e0 = en_cnt;
    tx_q = '{8'h0D, 8'h00, 8'h00};
    run_txn(3, -1);
    check("ignore_miso_en", en_cnt - e0, 32'd0);
    check("ignore_no_strobe", strobe_cnt - s0, 32'd0);
    tx_q = '{8'h0B, 8'h01, 8'h00};
    exp_q.push_back(8'h1D);
    run_txn(2, -1);

    // reset mid write-data byte
    cs = 1'b0;
    cyc(HP);
    spi_bits(8'h0A, 8, rx);
    spi_bits(8'h2D, 8, rx);
    spi_bits(8'hFF, 4, rx);
    cyc(2);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("midrst_miso", {31'd0, miso}, 32'd0);
    check("midrst_miso_en", {31'd0, miso_en}, 32'd0);
    check("midrst_power_ctl", {24'd0, power_ctl}, 32'h00);
    check("midrst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
    check("midrst_wr_addr", {26'd0, wr_addr}, 32'd0);
    cyc(HP);
    cs = 1'b1;
    cyc(2 * HP);
    tx_q = '{8'h0B, 8'h2D, 8'h00};
    exp_q.push_back(8'h00);
    run_txn(2, -1);

    check("scoreboard_leftover", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/acl_spi_responder.md
Name: acl_spi_responder

Overview:
- SPI mode-0 responder that emulates the ADXL362 register interface our spi_master talks to.
- Lets the accelerometer path run in simulation, and on a second board, without the real sensor.
- Samples SCLK/MOSI/CS synchronously in the 100 MHz domain.
- Decodes the 0x0A write / 0x0B read commands with address auto-increment, and serves ID, axis data and control registers.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on sclk/mosi/cs before edge detection (min 2).
- DEVID_AD, 8'hAD, value of register 0x00.
- PARTID, 8'hF2, value of register 0x02.

Ports:
- CLK100MHZ  input  1  system clock; sole clock.
- reset  input  1  synchronous, active-high reset.
- sclk  input  1  SPI clock from master, asynchronous to CLK100MHZ.
- mosi  input  1  master-out data.
- cs  input  1  chip select, active low.
- miso  output  1  responder data; 0 when not driving.
- miso_en  output  1  high while miso is being driven (for tristate at pin).
- x_data  input  8  current X sample.
- y_data  input  8  current Y sample.
- z_data  input  8  current Z sample.
- power_ctl  output  8  register 0x2D contents.
- wr_strobe  output  1  one-cycle pulse per completed register write.
- wr_addr  output  6  address of that write; valid with wr_strobe.

Behaviour:
- Clock and reset:
  - One clock (CLK100MHZ); reset is synchronous and active-high.
  - Reset values: miso=0, miso_en=0, power_ctl=0x00, wr_strobe=0, wr_addr=0, state=IDLE, bit counter=0.
- Input sync and edge detect:
  - sclk, mosi and cs each pass through SYNC_STAGES flops.
  - Edges are detected from the last stage against a delay flop.
  - Required timing: sclk high and low periods ≥ 6 CLK100MHZ cycles each.
- Framing:
  - A synchronized cs falling edge enters CMD, clears the bit counter, and snapshots x/y/z_data into shadow registers so one burst read is coherent.
  - A synchronized cs rising edge returns to IDLE from any state and sets miso_en=0 the next cycle. A partial byte is discarded and no write occurs.
- Shifting:
  - MOSI is sampled on each synchronized sclk rising edge, MSB first.
  - 8 bits complete a byte.
- State machine:
  - IDLE: waits for cs falling edge.
  - CMD: at byte end, 0x0A goes to ADDR with op=WR; 0x0B goes to ADDR with op=RD; any other value goes to IGNORE.
  - ADDR: at byte end, latch the low 6 bits of the byte as the address, then go to DATA.
  - DATA: loops until cs rises.
    - WR: each completed byte writes the register at the current address.
    - RD: each byte shifts out the register at the current address.
    - After each byte the address increments modulo 64; 0x3F wraps to 0x00.
  - IGNORE: miso_en=0, mosi is ignored, until cs rises.
- Read drive (mode 0):
  - On the synchronized sclk falling edge that ends the ADDR byte, load the read byte, assert miso_en and drive its MSB.
  - On each later falling edge, shift out the next bit.
  - After the 8th bit, the next falling edge loads the following address's byte.
  - miso is stable ≥ 3 cycles before the next rising edge given the required sclk timing.
- Register map (reads):
  - 0x00 = DEVID_AD
  - 0x01 = 0x1D
  - 0x02 = PARTID
  - 0x08/0x09/0x0A = X/Y/Z shadow
  - 0x0B = 0x41 (STATUS: data ready and awake)
  - 0x2D = power_ctl
  - All other addresses read 0x00.
- Writes:
  - Only 0x2D is stored. Writes to any other address are accepted but not stored.
  - wr_strobe pulses for every write, one cycle after the rising edge that completes the byte, with wr_addr set to that byte's address.
- Simultaneous events:
  - cs rising on the same cycle as the 8th rising edge: cs wins, and no write or strobe occurs.
  - reset asserted mid-transaction: reset takes effect at once; power_ctl returns to 0x00.
  - sclk edges while cs is high are ignored.
- Arithmetic: address is a 6-bit counter; bit counter is 3 bits and wraps 7→0 at byte completion.

Decomposition:
- Shared package acl_spi_pkg holds:
  - command constants CMD_WRITE=8'h0A and CMD_READ=8'h0B;
  - register address constants ADDR_DEVID_AD, ADDR_XDATA, ADDR_YDATA, ADDR_ZDATA, ADDR_STATUS, ADDR_POWER_CTL;
  - state encoding for IDLE, CMD, ADDR, DATA, IGNORE.
- One sub-module, spi_sync_edge: a SYNC_STAGES synchronizer plus rise/fall pulse outputs, instantiated for sclk and cs. mosi uses the synchronizer only.

Test Plan:
- Reset, then drive the master model with cs low, 0x0B, 0x00, one dummy byte → master receives 0xAD; miso_en falls ≤ SYNC_STAGES+2 cycles after cs rises.
- x/y/z = 0x12/0x34/0x56; burst 0x0B, 0x08 and 3 bytes, with x_data changed to 0x99 mid-burst → received 0x12, 0x34, 0x56 (snapshot holds).
- Write 0x0A, 0x2D, 0x02 → power_ctl=0x02; exactly one wr_strobe with wr_addr=0x2D; read back 0x2D returns 0x02.
- Burst read starting at 0x3F for 2 bytes → 0x00 then 0xAD (wrap to 0x00); cs raised after 4 bits of a write to 0x2D → power_ctl unchanged, no strobe.
- Command 0x0D, then 16 clocks → miso_en stays 0, no strobe; next transaction reads 0x01 = 0x1D correctly.
- Assert reset for 1 cycle mid-write-data byte → all outputs at reset values; a following read of 0x2D returns 0x00.
